// File: rtl/sobel_edge_calc.sv
// Sobel gradient magnitude and threshold stage: three-deep pipeline
// with back-pressure from the output packing buffer.
module sobel_edge_calc #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int MAG_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [71:0]      win,
    input  logic             win_valid,
    output logic             win_ready,
    input  logic [MAG_W-1:0] thresh,
    input  logic             out_full,
    output logic             edge_pixel,
    output logic             out_en,
    output logic [8:0]       out_row,
    output logic [9:0]       out_col,
    output logic             img_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [9:0] COL_LAST = 10'(IMG_W - 3);
    localparam logic [8:0] ROW_LAST = 9'(IMG_H - 3);

    state_t state;

    logic adv;
    logic accept;
    logic last_px;
    logic v1, v2, v3;

    logic signed [10:0] gx, gy;
    logic signed [10:0] gx_c, gy_c;
    logic [10:0] ax, ay;
    logic [MAG_W-1:0] mag, mag_c;

    function automatic logic signed [10:0] px(input logic [71:0] w, input int i);
        return $signed({3'b000, w[8*i +: 8]});
    endfunction

    assign adv       = !out_full;
    assign win_ready = (state == RUN) && adv;
    assign accept    = win_valid && win_ready;
    // A restart discards whatever would have fired this cycle.
    assign out_en    = v3 && adv && (state == RUN) && !start;
    assign last_px   = (out_row == ROW_LAST) && (out_col == COL_LAST);

    always_comb begin
        gx_c = (px(win, 2) + (px(win, 5) <<< 1) + px(win, 8))
             - (px(win, 0) + (px(win, 3) <<< 1) + px(win, 6));
        gy_c = (px(win, 6) + (px(win, 7) <<< 1) + px(win, 8))
             - (px(win, 0) + (px(win, 1) <<< 1) + px(win, 2));
        ax = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        mag_c = MAG_W'(ax + ay);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            gx         <= '0;
            gy         <= '0;
            mag        <= '0;
            edge_pixel <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            img_done   <= 1'b0;
        end else begin
            if (adv) begin
                gx         <= gx_c;
                gy         <= gy_c;
                mag        <= mag_c;
                edge_pixel <= (mag > thresh);
                v1         <= accept;
                v2         <= v1;
                v3         <= v2;
            end
            // A window taken on the start edge is the first of the new frame.
            if (start) begin
                state    <= RUN;
                v1       <= accept;
                v2       <= 1'b0;
                v3       <= 1'b0;
                out_row  <= '0;
                out_col  <= '0;
                img_done <= 1'b0;
            end else if (out_en) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + 9'd1;
                end else begin
                    out_col <= out_col + 10'd1;
                end
                if (last_px) begin
                    state    <= DONE;
                    img_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_calc.sv
// Bench for sobel_edge_calc on a 6x5 image (4x3 output) with a
// plain-integer Sobel reference model and per-scenario checks.
module tb_sobel_edge_calc;

    localparam int W    = 6;
    localparam int H    = 5;
    localparam int MW   = 11;
    localparam int OC   = W - 2;
    localparam int NPIX = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [71:0]   win = '0;
    logic          win_valid = 1'b0;
    logic          win_ready;
    logic [MW-1:0] thresh = '0;
    logic          out_full = 1'b0;
    logic          edge_pixel;
    logic          out_en;
    logic [8:0]    out_row;
    logic [9:0]    out_col;
    logic          img_done;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic       o_rdy, o_en, o_edge, o_done;
    logic [8:0] o_row;
    logic [9:0] o_col;

    always #5 clk = ~clk;

    sobel_edge_calc #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .win(win), .win_valid(win_valid), .win_ready(win_ready),
        .thresh(thresh), .out_full(out_full),
        .edge_pixel(edge_pixel), .out_en(out_en),
        .out_row(out_row), .out_col(out_col), .img_done(img_done)
    );

    function automatic int pix(input logic [71:0] w, input int i);
        logic [7:0] b;
        b = w[8*i +: 8];
        return int'(b);
    endfunction

    function automatic logic model_edge(input logic [71:0] w, input int th);
        int p[9];
        int gx, gy, mag;
        for (int i = 0; i < 9; i++) p[i] = pix(w, i);
        gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return mag > th;
    endfunction

    function automatic logic [71:0] pack9(input int p[9]);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'(p[i]);
        return w;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    // Drive one cycle of inputs at the falling edge and sample outputs 1ns later.
    task automatic step(input logic rs, input logic v, input logic [71:0] w,
                        input logic full, input logic st);
        @(negedge clk);
        rst = rs; win_valid = v; win = w; out_full = full; start = st;
        #1;
        o_rdy  = win_ready;
        o_en   = out_en;
        o_edge = edge_pixel;
        o_row  = out_row;
        o_col  = out_col;
        o_done = img_done;
        cyc_n++;
    endtask

    task automatic test_reset();
        step(1, 1, rand_win(), 0, 0);
        step(1, 1, rand_win(), 0, 1);
        checks += 6;
        if (o_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_rdy); end
        if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_en); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
        if (o_edge !== 1'b0) begin errors++; $display("FAIL reset_edge got %b want 0", o_edge); end
        if (o_row !== 9'd0) begin errors++; $display("FAIL reset_row got %0d want 0", o_row); end
        if (o_col !== 10'd0) begin errors++; $display("FAIL reset_col got %0d want 0", o_col); end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, rand_win(), 0, 0);
            checks += 2;
            if (o_rdy !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", o_rdy); end
            if (o_en !== 1'b0) begin errors++; $display("FAIL idle_en got %b want 0", o_en); end
        end
    endtask

    task automatic test_single_windows();
        int pf[9], pv[9], pm[9];
        logic [71:0] ws[7];
        int ths[7];
        int m, acc;
        logic got, exp;
        m = $urandom_range(0, 255);
        pf = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        pv = '{0, m, 255, 0, m, 255, 0, m, 255};
        pm = '{0, 0, 128, 0, 128, 255, 128, 255, 255};
        ws  = '{pack9(pf), pack9(pv), pack9(pv), pack9(pv), pack9(pm), pack9(pm), pack9(pm)};
        ths = '{0, 500, 1020, 1019, 2039, 1529, 1530};
        for (int t = 0; t < 7; t++) begin
            exp = model_edge(ws[t], ths[t]);
            thresh = MW'(ths[t]);
            step(0, 0, '0, 0, 1);
            step(0, 1, ws[t], 0, 0);
            acc = cyc_n;
            checks++;
            if (o_rdy !== 1'b1) begin errors++; $display("FAIL single%0d_ready got %b want 1", t, o_rdy); end
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                step(0, 0, '0, 0, 0);
                if (o_en === 1'b1) begin
                    got = 1'b1;
                    checks += 3;
                    if (cyc_n - acc != 3) begin errors++; $display("FAIL single%0d_latency got %0d want 3", t, cyc_n - acc); end
                    if (o_edge !== exp) begin errors++; $display("FAIL single%0d_edge got %b want %b", t, o_edge, exp); end
                    if (o_row !== 9'd0 || o_col !== 10'd0) begin
                        errors++; $display("FAIL single%0d_coord got %0d,%0d want 0,0", t, o_row, o_col);
                    end
                end
            end
            checks++;
            if (!got) begin errors++; $display("FAIL single%0d_timeout got none want out_en", t); end
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] ws[8];
        logic exp[8];
        int th, sent, got, stall;
        logic full;
        th = $urandom_range(200, 900);
        thresh = MW'(th);
        for (int i = 0; i < 8; i++) begin
            ws[i]  = rand_win();
            exp[i] = model_edge(ws[i], th);
        end
        step(0, 0, '0, 0, 1);
        sent = 0; got = 0; stall = 0;
        for (int k = 0; k < 80 && got < 8; k++) begin
            full = (stall > 0);
            step(0, sent < 8, ws[sent % 8], full, 0);
            if (full) begin
                stall--;
                checks += 2;
                if (o_rdy !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", o_rdy); end
                if (o_en !== 1'b0) begin errors++; $display("FAIL stall_en got %b want 0", o_en); end
            end
            if (o_en === 1'b1) begin
                checks += 3;
                if (got >= 8) begin errors++; $display("FAIL bp_extra got %0d want 8", got + 1); end
                else if (o_edge !== exp[got]) begin
                    errors++; $display("FAIL bp_edge%0d got %b want %b", got, o_edge, exp[got]);
                end
                if (o_col !== 10'(got % OC)) begin errors++; $display("FAIL bp_col%0d got %0d want %0d", got, o_col, got % OC); end
                if (o_row !== 9'(got / OC)) begin errors++; $display("FAIL bp_row%0d got %0d want %0d", got, o_row, got / OC); end
                got++;
            end
            if (sent < 8 && o_rdy === 1'b1) begin
                sent++;
                if (sent == 2) stall = 5;
                if (sent == 6) stall = 3;
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, '0, 0, 0);
            if (o_en === 1'b1) got++;
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL bp_count got %0d want 8", got); end
    endtask

    task automatic test_frame_end();
        logic [71:0] ws[NPIX];
        logic exp[NPIX];
        int th, sent, got;
        logic full;
        th = $urandom_range(300, 1000);
        thresh = MW'(th);
        for (int i = 0; i < NPIX; i++) begin
            ws[i]  = rand_win();
            exp[i] = model_edge(ws[i], th);
        end
        step(0, 0, '0, 0, 1);
        sent = 0; got = 0;
        for (int k = 0; k < 200 && got < NPIX; k++) begin
            full = ($urandom_range(0, 3) == 0);
            step(0, sent < NPIX, ws[sent % NPIX], full, 0);
            if (o_en === 1'b1) begin
                checks += 4;
                if (o_edge !== exp[got]) begin errors++; $display("FAIL fe_edge%0d got %b want %b", got, o_edge, exp[got]); end
                if (o_col !== 10'(got % OC)) begin errors++; $display("FAIL fe_col%0d got %0d want %0d", got, o_col, got % OC); end
                if (o_row !== 9'(got / OC)) begin errors++; $display("FAIL fe_row%0d got %0d want %0d", got, o_row, got / OC); end
                if (o_done !== 1'b0) begin errors++; $display("FAIL fe_early_done%0d got %b want 0", got, o_done); end
                got++;
            end
            if (sent < NPIX && o_rdy === 1'b1) sent++;
        end
        checks++;
        if (got != NPIX) begin errors++; $display("FAIL fe_count got %0d want %0d", got, NPIX); end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, rand_win(), 0, 0);
            checks += 3;
            if (o_done !== 1'b1) begin errors++; $display("FAIL fe_done got %b want 1", o_done); end
            if (o_rdy !== 1'b0) begin errors++; $display("FAIL fe_ready got %b want 0", o_rdy); end
            if (o_en !== 1'b0) begin errors++; $display("FAIL fe_en got %b want 0", o_en); end
        end
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);
        checks += 2;
        if (o_done !== 1'b0) begin errors++; $display("FAIL fe_restart_done got %b want 0", o_done); end
        if (o_rdy !== 1'b1) begin errors++; $display("FAIL fe_restart_ready got %b want 1", o_rdy); end
    endtask

    task automatic test_restart();
        logic [71:0] w;
        int th, got, acc;
        th = $urandom_range(200, 900);
        thresh = MW'(th);
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, rand_win(), 0, 0);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, '0, 0, 0);
            if (o_en === 1'b1) got++;
        end
        checks += 2;
        if (got != 3) begin errors++; $display("FAIL rs_pre_count got %0d want 3", got); end
        if (o_col !== 10'd3) begin errors++; $display("FAIL rs_pre_col got %0d want 3", o_col); end
        step(0, 1, rand_win(), 0, 0);
        step(0, 1, rand_win(), 0, 0);
        step(0, 0, '0, 0, 1);
        w = rand_win();
        step(0, 1, w, 0, 0);
        acc = cyc_n;
        checks += 2;
        if (o_rdy !== 1'b1) begin errors++; $display("FAIL rs_ready got %b want 1", o_rdy); end
        if (o_col !== 10'd0 || o_row !== 9'd0) begin
            errors++; $display("FAIL rs_clear got %0d,%0d want 0,0", o_row, o_col);
        end
        got = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, '0, 0, 0);
            if (o_en === 1'b1) begin
                got++;
                checks += 3;
                if (cyc_n - acc != 3) begin errors++; $display("FAIL rs_latency got %0d want 3", cyc_n - acc); end
                if (o_col !== 10'd0 || o_row !== 9'd0) begin
                    errors++; $display("FAIL rs_coord got %0d,%0d want 0,0", o_row, o_col);
                end
                if (o_edge !== model_edge(w, th)) begin
                    errors++; $display("FAIL rs_edge got %b want %b", o_edge, model_edge(w, th));
                end
            end
        end
        checks++;
        if (got != 1) begin errors++; $display("FAIL rs_count got %0d want 1", got); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, rand_win(), 0, 0);
        step(1, 1, rand_win(), 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, rand_win(), 0, 0);
            checks += 3;
            if (o_en !== 1'b0) begin errors++; $display("FAIL rm_en got %b want 0", o_en); end
            if (o_rdy !== 1'b0) begin errors++; $display("FAIL rm_ready got %b want 0", o_rdy); end
            if (o_col !== 10'd0 || o_row !== 9'd0) begin
                errors++; $display("FAIL rm_coord got %0d,%0d want 0,0", o_row, o_col);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_windows();
        test_back_to_back();
        test_frame_end();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
